// File: rtl/channel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : channel_scan_ctrl
// Description : Scans the three inputs of a downstream 3-input mux by walking
//               its two select lines through channels 0, 1 and 2. Each channel
//               is given SETTLE cycles to settle and is then sampled for one
//               cycle. After the third channel is sampled, the three bits are
//               published together as one frame.
//
//               Ports
//                 clk         : rising-edge clock
//                 rst         : asynchronous, active-high reset
//                 en          : scan enable (level-sensitive)
//                 mux_out     : output of the downstream mux
//                 sel1        : first-rank select (i1 over i0)
//                 sel0        : second-rank select (i2 over first rank)
//                 ch          : current channel index, 0..2
//                 busy        : high while the scan is in SETTLE or SAMPLE
//                 frame       : last complete frame, bit k = channel k
//                 frame_valid : one-cycle pulse when frame updates
//                 frame_cnt   : frames completed since reset, wraps 255->0
//
//               Parameters
//                 SETTLE      : settle cycles per channel (1..15)
//                 MAX_FRAMES  : frames per run, 0 = continuous while en=1
// Revision    : 1.0 - initial release
// ============================================================================
module channel_scan_ctrl #(
    parameter int SETTLE     = 2,
    parameter int MAX_FRAMES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mux_out,
    output logic       sel1,
    output logic       sel0,
    output logic [1:0] ch,
    output logic       busy,
    output logic [2:0] frame,
    output logic       frame_valid,
    output logic [7:0] frame_cnt
);

    // State encoding
    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_settle = 2'd1;
    localparam logic [1:0] c_sample = 2'd2;

    // Settle down-counter reload: reaching zero ends the settle phase, so a
    // load of SETTLE-1 yields exactly SETTLE cycles in SETTLE.
    localparam logic [3:0] c_settle_load = 4'(SETTLE - 1);

    // The run counter only needs to reach MAX_FRAMES-1 (the index of the
    // last frame of a run).
    localparam int c_run_w = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam logic [c_run_w-1:0] c_run_last =
        (MAX_FRAMES > 0) ? c_run_w'(MAX_FRAMES - 1) : '0;

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic [1:0]         r_shadow;   // channels 0 and 1; channel 2 goes straight to frame
    logic [c_run_w-1:0] r_run;
    logic               r_armed;    // en has been low since the last limit-stop

    logic w_last_frame;
    logic w_continue;

    assign w_last_frame = (MAX_FRAMES > 0) && (r_run == c_run_last);
    assign w_continue   = en && !w_last_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_cnt       <= 4'd0;
            r_shadow    <= 2'b00;
            r_run       <= '0;
            r_armed     <= 1'b1;
            ch          <= 2'd0;
            sel1        <= 1'b0;
            sel0        <= 1'b0;
            busy        <= 1'b0;
            frame       <= 3'b000;
            frame_valid <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            frame_valid <= 1'b0;

            // Any low cycle of en re-arms a run stopped by the frame limit.
            if (!en) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                c_idle: begin
                    if (en && r_armed) begin
                        r_state <= c_settle;
                        r_cnt   <= c_settle_load;
                        r_run   <= '0;
                        ch      <= 2'd0;
                        sel1    <= 1'b0;
                        sel0    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                c_settle: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_sample;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                c_sample: begin
                    if (ch != 2'd2) begin
                        // ch is 0 or 1 here, so its low bit selects the shadow slot.
                        r_shadow[ch[0]] <= mux_out;
                        ch      <= ch + 2'd1;
                        // Select for the next channel, registered alongside ch.
                        sel1    <= (ch == 2'd0);
                        sel0    <= (ch == 2'd1);
                        r_state <= c_settle;
                        r_cnt   <= c_settle_load;
                    end else begin
                        frame       <= {mux_out, r_shadow};
                        frame_valid <= 1'b1;
                        frame_cnt   <= frame_cnt + 8'd1;
                        r_shadow    <= 2'b00;
                        ch          <= 2'd0;
                        sel1        <= 1'b0;
                        sel0        <= 1'b0;
                        if (w_continue) begin
                            r_state <= c_settle;
                            r_cnt   <= c_settle_load;
                            r_run   <= r_run + 1'b1;
                        end else begin
                            r_state <= c_idle;
                            busy    <= 1'b0;
                            // Stopped by the frame limit: demand an en low cycle.
                            if (en) begin
                                r_armed <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= c_idle;
                    busy    <= 1'b0;
                    ch      <= 2'd0;
                    sel1    <= 1'b0;
                    sel0    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_channel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel_scan_ctrl
// Description : Self-checking bench for channel_scan_ctrl. Two instances:
//               u0 (SETTLE=2, continuous) and u1 (SETTLE=3, MAX_FRAMES=2).
//               A schedule-based reference model predicts each cycle's
//               outputs and pushes expected frames into per-instance queues;
//               a monitor pops them on frame_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_scan_ctrl;

    localparam int S0 = 2;
    localparam int M0 = 0;
    localparam int S1 = 3;
    localparam int M1 = 2;

    logic clk;
    logic rst;
    logic en0;
    logic en1;
    logic i0;
    logic i1;
    logic i2;
    logic mux0;
    logic mux1;

    logic       sel1_0, sel0_0, busy_0, fv_0;
    logic [1:0] ch_0;
    logic [2:0] frame_0;
    logic [7:0] fc_0;
    logic       sel1_1, sel0_1, busy_1, fv_1;
    logic [1:0] ch_1;
    logic [2:0] frame_1;
    logic [7:0] fc_1;

    int errors = 0;
    int checks = 0;

    // Downstream mux: sel0 picks i2 over the first-rank result.
    assign mux0 = sel0_0 ? i2 : (sel1_0 ? i1 : i0);
    assign mux1 = sel0_1 ? i2 : (sel1_1 ? i1 : i0);

    channel_scan_ctrl #(.SETTLE(S0), .MAX_FRAMES(M0)) u0 (
        .clk(clk), .rst(rst), .en(en0), .mux_out(mux0),
        .sel1(sel1_0), .sel0(sel0_0), .ch(ch_0), .busy(busy_0),
        .frame(frame_0), .frame_valid(fv_0), .frame_cnt(fc_0)
    );

    channel_scan_ctrl #(.SETTLE(S1), .MAX_FRAMES(M1)) u1 (
        .clk(clk), .rst(rst), .en(en1), .mux_out(mux1),
        .sel1(sel1_1), .sel0(sel0_1), .ch(ch_1), .busy(busy_1),
        .frame(frame_1), .frame_valid(fv_1), .frame_cnt(fc_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A run is a sequence of cycle positions; channel k is sampled at
    // position k*(S+1)+S and the frame publishes at the edge ending
    // position 3*(S+1)-1.
    bit       m_run   [2];
    int       m_pos   [2];
    bit       m_armed [2];
    int       m_frames[2];
    bit [2:0] m_bits  [2];
    bit [2:0] m_frame [2];
    int       m_cnt   [2];
    bit       m_fv    [2];
    logic [10:0] q0[$];
    logic [10:0] q1[$];

    task automatic model_reset(input int u);
        m_run[u]    = 1'b0;
        m_pos[u]    = 0;
        m_armed[u]  = 1'b1;
        m_frames[u] = 0;
        m_bits[u]   = 3'b000;
        m_frame[u]  = 3'b000;
        m_cnt[u]    = 0;
        m_fv[u]     = 1'b0;
    endtask

    task automatic model_step(input int u, input int s, input int mx, input bit e);
        int k;
        m_fv[u] = 1'b0;
        if (!m_run[u]) begin
            if (e && m_armed[u]) begin
                m_run[u]    = 1'b1;
                m_pos[u]    = 0;
                m_frames[u] = 0;
            end
        end else begin
            if ((m_pos[u] % (s + 1)) == s) begin
                k = m_pos[u] / (s + 1);
                m_bits[u][k] = (k == 0) ? i0 : ((k == 1) ? i1 : i2);
            end
            if (m_pos[u] == 3 * (s + 1) - 1) begin
                m_frame[u] = m_bits[u];
                m_cnt[u]   = (m_cnt[u] + 1) % 256;
                m_fv[u]    = 1'b1;
                m_frames[u]++;
                if (e && !(mx > 0 && m_frames[u] == mx)) begin
                    m_pos[u] = 0;
                end else begin
                    m_run[u] = 1'b0;
                    if (e) m_armed[u] = 1'b0;
                end
            end else begin
                m_pos[u]++;
            end
        end
        if (!e) m_armed[u] = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
            q0.delete();
            q1.delete();
        end else begin
            model_step(0, S0, M0, en0);
            model_step(1, S1, M1, en1);
            if (m_fv[0]) q0.push_back({8'(m_cnt[0]), m_frame[0]});
            if (m_fv[1]) q1.push_back({8'(m_cnt[1]), m_frame[1]});
        end
    end

    function automatic logic [16:0] exp_vec(input int u, input int s);
        int c;
        c = m_run[u] ? (m_pos[u] / (s + 1)) : 0;
        return {m_run[u], 2'(c), (c == 1), (c == 2), m_fv[u], m_frame[u], 8'(m_cnt[u])};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [16:0] a;
        logic [16:0] x;
        logic [10:0] e;
        if (!rst) begin
            a = {busy_0, ch_0, sel1_0, sel0_0, fv_0, frame_0, fc_0};
            x = exp_vec(0, S0);
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL u0_cycle t=%0t got=%h want=%h", $time, a, x);
            end
            a = {busy_1, ch_1, sel1_1, sel0_1, fv_1, frame_1, fc_1};
            x = exp_vec(1, S1);
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL u1_cycle t=%0t got=%h want=%h", $time, a, x);
            end
            if (fv_0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL u0_frame t=%0t got=%h want=none", $time, {fc_0, frame_0});
                end else begin
                    e = q0.pop_front();
                    if ({fc_0, frame_0} !== e) begin
                        errors++;
                        $display("FAIL u0_frame t=%0t got=%h want=%h", $time, {fc_0, frame_0}, e);
                    end
                end
            end
            if (fv_1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL u1_frame t=%0t got=%h want=none", $time, {fc_1, frame_1});
                end else begin
                    e = q1.pop_front();
                    if ({fc_1, frame_1} !== e) begin
                        errors++;
                        $display("FAIL u1_frame t=%0t got=%h want=%h", $time, {fc_1, frame_1}, e);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
        i0 = 1'($urandom % 2);
        i1 = 1'($urandom % 2);
        i2 = 1'($urandom % 2);
    endtask

    task automatic check_reset_values(input string tag);
        logic [16:0] a;
        a = {busy_0, ch_0, sel1_0, sel0_0, fv_0, frame_0, fc_0};
        checks++;
        if (a !== 17'd0) begin
            errors++;
            $display("FAIL %s_u0 got=%h want=00000", tag, a);
        end
        a = {busy_1, ch_1, sel1_1, sel0_1, fv_1, frame_1, fc_1};
        checks++;
        if (a !== 17'd0) begin
            errors++;
            $display("FAIL %s_u1 got=%h want=00000", tag, a);
        end
    endtask

    initial begin
        rst = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        i0  = 1'b1;
        i1  = 1'b0;
        i2  = 1'b1;
        #1;
        check_reset_values("reset_init");
        repeat (3) tick();
        check_reset_values("reset_hold");

        // en already high when reset releases: scan starts on the first edge.
        en0 = 1'b1;
        en1 = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Continuous run on u0; u1 stops after two frames and must stay idle.
        repeat (120) tick();

        // Re-arm u1 with a single low cycle, then two more frames.
        en1 = 1'b0;
        tick();
        en1 = 1'b1;
        repeat (60) tick();

        // Random enable toggling: mid-frame drops and restarts.
        for (int n = 0; n < 2000; n++) begin
            tick();
            if ($urandom_range(0, 19) == 0) en0 = ~en0;
            if ($urandom_range(0, 19) == 0) en1 = ~en1;
        end

        // Reset in the middle of a frame: outputs clear at once.
        en0 = 1'b1;
        en1 = 1'b1;
        repeat (14) tick();
        rst = 1'b1;
        #1;
        check_reset_values("reset_mid");
        repeat (2) tick();
        rst = 1'b0;

        // Long continuous run so frame_cnt on u0 wraps past 255.
        repeat (260 * 3 * (S0 + 1)) tick();
        en0 = 1'b0;
        en1 = 1'b0;
        repeat (3 * (S1 + 1) + 4) tick();

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL pending_frames got=%0d/%0d want=0/0", q0.size(), q1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/channel_scan_ctrl.md
CHANNEL_SCAN_CTRL -- requirements
Module: channel_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 2: wait cycles after each select change before sampling (legal 1..15).
REQ-002 Parameter MAX_FRAMES, default 0: frames per scan run; 0 means run continuously while en is high.
REQ-003 Reset is asynchronous and active-high; the block has one clock.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  scan enable; level-sensitive.
REQ-007 mux_out  input  1  output of the downstream 3-input mux driven by sel0/sel1.
REQ-008 sel1  output  1  mux select, first rank (picks i1 over i0).
REQ-009 sel0  output  1  mux select, second rank (picks i2 over first-rank result).
REQ-010 ch  output  2  current channel index, 0..2.
REQ-011 busy  output  1  high while in SETTLE or SAMPLE.
REQ-012 frame  output  3  last complete frame; bit k holds channel k.
REQ-013 frame_valid  output  1  one-cycle pulse when frame updates.
REQ-014 frame_cnt  output  8  completed frames since reset; wraps 255->0.

Function
REQ-015 Channel-to-select map SHALL be registered: ch0 -> sel1=0, sel0=0; ch1 -> sel1=1, sel0=0; ch2 -> sel1=0, sel0=1.
REQ-016 sel0/sel1 SHALL change only on the clock edge where ch changes, and never take the value sel1=1, sel0=1.
REQ-017 FSM states: IDLE, SETTLE, SAMPLE.
REQ-018 IDLE -> SETTLE when en=1; ch SHALL be set to 0 on that edge.
REQ-019 SETTLE SHALL last exactly SETTLE cycles (down-counter loaded with SETTLE-1), then go to SAMPLE.
REQ-020 SAMPLE lasts one cycle: mux_out SHALL be captured into a shadow bit at index ch.
REQ-021 From SAMPLE with ch<2: ch increments, go to SETTLE.
REQ-022 From SAMPLE with ch=2: on the next edge, frame <= shadow with the ch2 bit included, frame_valid=1 for one cycle, and frame_cnt increments.
REQ-023 After REQ-022, go to SETTLE with ch=0 if en=1 and the run limit is not reached; otherwise go to IDLE with ch=0.
REQ-024 Per-channel period SHALL be SETTLE+1 cycles; frame period SHALL be 3*(SETTLE+1) cycles.
REQ-025 First frame_valid SHALL assert 3*(SETTLE+1) cycles after the edge leaving IDLE.
REQ-026 en deasserted mid-frame: the current frame SHALL complete and publish, then the FSM SHALL enter IDLE; no partial frame is ever published.
REQ-027 MAX_FRAMES>0: after MAX_FRAMES frames in one run, return to IDLE even if en=1; a new run SHALL require en low for at least one cycle, then high.
REQ-028 busy=1 exactly when the state is SETTLE or SAMPLE.
REQ-029 frame holds its value between updates; frame_valid=0 in all other cycles.
REQ-030 frame_cnt wraps 255->0 with no flag.

Reset
REQ-031 On rst=1, asynchronously: state=IDLE, ch=0, sel0=0, sel1=0, busy=0, frame=3'b000, frame_valid=0, frame_cnt=0, shadow=0, settle counter=0, run counter=0.
REQ-032 Reset mid-frame SHALL discard the partial shadow; no frame_valid SHALL follow.
REQ-033 After rst falls, with en=1 already high, the scan SHALL start on the first clock edge.

Verification
REQ-034 SETTLE=2, en=1, mux input per channel modelled as i0=1, i1=0, i2=1 -> frame_valid at cycle 9 after start, frame=3'b101, frame_cnt=1.
REQ-035 Same setup, run continuously -> frame_valid every 9 cycles; sel pattern (sel1,sel0) = 00,00,00,10,10,10,01,01,01 repeating; 11 never seen.
REQ-036 en dropped at cycle 4 of a frame -> frame completes at cycle 9, frame_valid pulses once, busy falls on the next cycle, ch=0.
REQ-037 MAX_FRAMES=2, en held high -> exactly 2 frame_valid pulses, then IDLE; en toggled low then high -> 2 more pulses.
REQ-038 rst asserted at cycle 5 of a frame -> all outputs take reset values immediately; no frame_valid until a full new frame completes.
REQ-039 Run 256 frames -> frame_cnt reads 0 after the 256th pulse.
